// File: rtl/uart_tx_fifo_if.sv
// Bus between a CPU-side writer and the UART transmit FIFO.
// Signal prefixes are from the FIFO's point of view.
interface uart_tx_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 4
) ();
  logic                  i_wr_en;
  logic [7:0]            i_wr_data;
  logic                  i_flush;
  logic                  i_clr_overflow;
  logic                  i_tx_ready;
  logic                  o_tx_strobe;
  logic [7:0]            o_tx_byte;
  logic                  o_full;
  logic                  o_empty;
  logic [DEPTH_LOG2:0]   o_count;
  logic                  o_overflow;
  logic                  o_busy;

  modport master (
    output i_wr_en, i_wr_data, i_flush, i_clr_overflow, i_tx_ready,
    input  o_tx_strobe, o_tx_byte, o_full, o_empty, o_count, o_overflow, o_busy
  );

  modport slave (
    input  i_wr_en, i_wr_data, i_flush, i_clr_overflow, i_tx_ready,
    output o_tx_strobe, o_tx_byte, o_full, o_empty, o_count, o_overflow, o_busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: circular buffer plus a drain FSM that
// issues one load strobe per byte and waits for the transmitter to go busy and idle again.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input logic           clock,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);
  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone} state_e;

  state_e                r_state;
  logic [7:0]            r_mem [Depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_tx_strobe;
  logic [7:0]            r_tx_byte;
  logic                  r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_drop;

  assign w_full  = (r_count == (DEPTH_LOG2 + 1)'(Depth));
  assign w_empty = (r_count == '0);
  // Flush swallows a same-cycle write silently and blocks any issue.
  assign w_push  = bus.i_wr_en & ~w_full & ~bus.i_flush;
  assign w_drop  = bus.i_wr_en & w_full & ~bus.i_flush;
  assign w_pop   = (r_state == StIdle) & ~w_empty & bus.i_tx_ready & ~bus.i_flush;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.i_wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= StIdle;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_tx_strobe <= 1'b0;
      r_tx_byte   <= 8'h00;
      r_overflow  <= 1'b0;
    end else begin
      if (bus.i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.i_clr_overflow) begin
        r_overflow <= 1'b0;
      end

      case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_tx_strobe <= 1'b1;
            r_tx_byte   <= r_mem[r_rd_ptr];
            r_state     <= StWaitBusy;
          end else begin
            r_tx_strobe <= 1'b0;
          end
        end
        StWaitBusy: begin
          r_tx_strobe <= 1'b0;
          if (!bus.i_tx_ready) r_state <= StWaitDone;
        end
        StWaitDone: begin
          r_tx_strobe <= 1'b0;
          if (bus.i_tx_ready) r_state <= StIdle;
        end
        default: begin
          r_tx_strobe <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign bus.o_tx_strobe = r_tx_strobe;
  assign bus.o_tx_byte   = r_tx_byte;
  assign bus.o_full      = w_full;
  assign bus.o_empty     = w_empty;
  assign bus.o_count     = r_count;
  assign bus.o_overflow  = r_overflow;
  assign bus.o_busy      = (r_state != StIdle) | ~w_empty;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model compared every cycle, directed
// scenarios with literal expectations, then a randomized soak.
module tb_uart_tx_fifo;
  localparam int unsigned DepthLog2 = 4;
  localparam int unsigned Depth     = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  uart_tx_fifo_if #(.DEPTH_LOG2(DepthLog2)) bus ();

  uart_tx_fifo #(.DEPTH_LOG2(DepthLog2)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending bytes and the transmitter handshake phase
  // (0 = free to issue, 1 = issued and waiting for ready to drop, 2 = waiting for it to rise).
  logic [7:0] q[$];
  int         phase    = 0;
  bit         m_strobe = 0;
  logic [7:0] m_byte   = 8'h00;
  bit         m_ovf    = 0;
  bit         started  = 0;
  bit         m_issue;
  bit         m_full_pre;

  always @(posedge clock) begin
    started = 1;
    if (reset) begin
      q.delete();
      phase    = 0;
      m_strobe = 0;
      m_byte   = 8'h00;
      m_ovf    = 0;
    end else begin
      m_full_pre = (q.size() == Depth);
      m_issue    = (phase == 0) && (q.size() > 0) && bus.i_tx_ready && !bus.i_flush;
      m_strobe   = 0;
      if (phase == 1 && !bus.i_tx_ready) phase = 2;
      else if (phase == 2 && bus.i_tx_ready) phase = 0;
      if (m_issue) begin
        m_byte   = q.pop_front();
        m_strobe = 1;
        phase    = 1;
      end
      if (bus.i_clr_overflow) m_ovf = 0;
      if (bus.i_flush) q.delete();
      else if (bus.i_wr_en) begin
        if (m_full_pre) m_ovf = 1;
        else q.push_back(bus.i_wr_data);
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      check("tx_strobe", bus.o_tx_strobe, m_strobe);
      check("tx_byte", bus.o_tx_byte, m_byte);
      check("count", bus.o_count, q.size());
      check("empty", bus.o_empty, q.size() == 0);
      check("full", bus.o_full, q.size() == Depth);
      check("overflow", bus.o_overflow, m_ovf);
      check("busy", bus.o_busy, (phase != 0) || (q.size() != 0));
    end
  end

  // Transmitter model: after each strobe, ready drops for hold_max cycles.
  bit         tx_auto   = 0;
  bit         tx_random = 0;
  bit         tx_level  = 1;
  int         hold      = 0;
  int         n_strobes = 0;
  bit         rec       = 0;
  logic [7:0] seen[$];

  always @(negedge clock) begin
    if (bus.o_tx_strobe) begin
      n_strobes++;
      if (rec) seen.push_back(bus.o_tx_byte);
    end
    #2;
    if (tx_auto) begin
      if (bus.o_tx_strobe) hold = tx_random ? int'($urandom_range(1, 6)) : 10;
      if (hold > 0) begin
        bus.i_tx_ready = 1'b0;
        hold--;
      end else begin
        bus.i_tx_ready = 1'b1;
      end
    end else begin
      bus.i_tx_ready = tx_level;
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_data = d;
    step();
    bus.i_wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!bus.o_busy) break;
      step();
    end
    check("drain_timeout", i >= budget, 0);
  endtask

  int s0;

  initial begin
    bus.i_wr_en        = 1'b0;
    bus.i_wr_data      = 8'h00;
    bus.i_flush        = 1'b0;
    bus.i_clr_overflow = 1'b0;
    bus.i_tx_ready     = 1'b1;
    reset              = 1'b1;
    step();
    step();
    check("rst_strobe", bus.o_tx_strobe, 0);
    check("rst_byte", bus.o_tx_byte, 0);
    check("rst_count", bus.o_count, 0);
    check("rst_empty", bus.o_empty, 1);
    check("rst_busy", bus.o_busy, 0);
    reset = 1'b0;

    // Single byte: strobe two edges after the write.
    tx_auto = 1;
    write_byte(8'h41);
    check("lat_strobe_early", bus.o_tx_strobe, 0);
    check("lat_count1", bus.o_count, 1);
    step();
    check("lat_strobe", bus.o_tx_strobe, 1);
    check("lat_byte", bus.o_tx_byte, 8'h41);
    check("lat_count0", bus.o_count, 0);
    wait_idle(100);

    // Fill with transmitter held busy, then overflow and clear.
    tx_auto  = 0;
    tx_level = 0;
    for (int i = 1; i <= 16; i++) write_byte(8'(i));
    check("fill_count", bus.o_count, 16);
    check("fill_full", bus.o_full, 1);
    check("fill_ovf0", bus.o_overflow, 0);
    write_byte(8'h11);
    check("ovf_set", bus.o_overflow, 1);
    check("ovf_count", bus.o_count, 16);
    bus.i_clr_overflow = 1'b1;
    step();
    bus.i_clr_overflow = 1'b0;
    check("ovf_clr", bus.o_overflow, 0);

    // Write into a full FIFO on the same edge as a pop: dropped.
    tx_auto = 1;
    write_byte(8'h99);
    check("pop_wr_count", bus.o_count, 15);
    check("pop_wr_ovf", bus.o_overflow, 1);
    check("pop_wr_byte", bus.o_tx_byte, 8'h01);
    wait_idle(600);

    // Ordered issue through the slow transmitter.
    seen.delete();
    rec = 1;
    write_byte(8'hA5);
    write_byte(8'h5A);
    write_byte(8'hFF);
    wait_idle(200);
    rec = 0;
    check("order_n", seen.size(), 3);
    if (seen.size() == 3) begin
      check("order0", seen[0], 8'hA5);
      check("order1", seen[1], 8'h5A);
      check("order2", seen[2], 8'hFF);
    end

    // Flush while the transmitter is busy with the first of five bytes.
    s0 = n_strobes;
    for (int i = 0; i < 5; i++) write_byte(8'(8'h50 + i));
    bus.i_flush = 1'b1;
    step();
    bus.i_flush = 1'b0;
    check("flush_count", bus.o_count, 0);
    check("flush_empty", bus.o_empty, 1);
    repeat (30) step();
    check("flush_strobes", n_strobes - s0, 1);
    check("flush_busy", bus.o_busy, 0);

    // Reset while waiting for the transmitter to go busy, with three bytes queued.
    tx_auto  = 0;
    tx_level = 1;
    for (int i = 0; i < 4; i++) write_byte(8'(8'h21 + i));
    check("pre_rst_count", bus.o_count, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_strobe", bus.o_tx_strobe, 0);
    check("mid_rst_byte", bus.o_tx_byte, 0);
    check("mid_rst_count", bus.o_count, 0);
    check("mid_rst_full", bus.o_full, 0);
    check("mid_rst_busy", bus.o_busy, 0);
    tx_auto = 1;
    write_byte(8'h33);
    step();
    check("post_rst_strobe", bus.o_tx_strobe, 1);
    check("post_rst_byte", bus.o_tx_byte, 8'h33);
    wait_idle(100);

    // Randomized soak.
    tx_random = 1;
    for (int c = 0; c < 4000; c++) begin
      bus.i_wr_en        = ($urandom_range(0, 99) < 55);
      bus.i_wr_data      = 8'($urandom);
      bus.i_flush        = ($urandom_range(0, 99) < 2);
      bus.i_clr_overflow = ($urandom_range(0, 99) < 8);
      reset              = ($urandom_range(0, 999) < 3);
      step();
    end
    bus.i_wr_en        = 1'b0;
    bus.i_flush        = 1'b0;
    bus.i_clr_overflow = 1'b0;
    reset              = 1'b0;
    wait_idle(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
